// File: rtl/inst_encode_if.sv
// Field-set stream in, instruction-memory write port and session status out.
interface inst_encode_if #(
    parameter int ADDRESS_WIDTH   = 2,
    parameter int OPCODE_WIDTH    = 4,
    parameter int FUNCTION_WIDTH  = 8,
    parameter int INST_WIDTH      = 18,
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic                       i_start;
    logic [IMEM_ADDR_WIDTH-1:0] i_base_addr;
    logic                       i_valid;
    logic                       o_ready;
    logic                       i_last;
    logic [OPCODE_WIDTH-1:0]    i_opcode;
    logic [ADDRESS_WIDTH-1:0]   i_rd;
    logic [ADDRESS_WIDTH-1:0]   i_rs1;
    logic [ADDRESS_WIDTH-1:0]   i_rs2;
    logic [FUNCTION_WIDTH-1:0]  i_funct;
    logic [13:0]                i_imm;
    logic                       o_imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
    logic [INST_WIDTH-1:0]      o_imem_wdata;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_error;
    logic [IMEM_ADDR_WIDTH:0]   o_count;

    // Program generator / loader side
    modport master (
        output i_start, i_base_addr, i_valid, i_last, i_opcode,
               i_rd, i_rs1, i_rs2, i_funct, i_imm,
        input  o_ready, o_imem_we, o_imem_addr, o_imem_wdata,
               o_busy, o_done, o_error, o_count
    );

    // Encoder side
    modport slave (
        input  i_start, i_base_addr, i_valid, i_last, i_opcode,
               i_rd, i_rs1, i_rs2, i_funct, i_imm,
        output o_ready, o_imem_we, o_imem_addr, o_imem_wdata,
               o_busy, o_done, o_error, o_count
    );
endinterface

// File: rtl/inst_encode.sv
// Instruction encoder / program loader: packs field sets into instruction
// words and writes them to consecutive instruction-memory addresses.
module inst_encode #(
    parameter int ADDRESS_WIDTH   = 2,
    parameter int OPCODE_WIDTH    = 4,
    parameter int FUNCTION_WIDTH  = 8,
    parameter int INST_WIDTH      = 18,
    parameter int IMEM_ADDR_WIDTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    inst_encode_if.slave  bus
);
    // Opcode assignments shared with the decoder
    localparam logic [OPCODE_WIDTH-1:0] OP_R_TYPE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDR    = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_STR    = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE    = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = OPCODE_WIDTH'(6);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;

    logic [IMEM_ADDR_WIDTH-1:0] ptr_q;
    logic [IMEM_ADDR_WIDTH-1:0] acc_cnt_q;
    logic [IMEM_ADDR_WIDTH:0]   count_q;
    logic                       error_q;
    logic                       we_q;
    logic [IMEM_ADDR_WIDTH-1:0] waddr_q;
    logic [INST_WIDTH-1:0]      wdata_q;

    logic [OPCODE_WIDTH-1:0]    op;
    logic [ADDRESS_WIDTH-1:0]   rd, rs1, rs2;
    logic [FUNCTION_WIDTH-1:0]  funct;
    logic [13:0]                imm;

    logic                       word_ok;
    logic [INST_WIDTH-1:0]      word_d;
    logic                       transfer;
    logic                       accept;
    logic                       reject;
    logic                       full_hit;
    logic                       start_session;

    assign op    = bus.i_opcode;
    assign rd    = bus.i_rd;
    assign rs1   = bus.i_rs1;
    assign rs2   = bus.i_rs2;
    assign funct = bus.i_funct;
    assign imm   = bus.i_imm;

    // Encode the presented field set and decide whether it is legal
    always_comb begin
        word_ok = 1'b0;
        word_d  = '0;
        case (op)
            OP_R_TYPE: begin
                word_ok = 1'b1;
                word_d  = {op, rd, rs1, rs2, funct};
            end
            OP_LDR, OP_STR, OP_ADDI, OP_SUBI, OP_BNE: begin
                // The 8-bit immediate must be representable: upper bits
                // have to be a pure sign extension of bit 7.
                word_ok = (imm[13:8] == {6{imm[7]}});
                word_d  = {op, rd, rs1, {ADDRESS_WIDTH{1'b0}}, imm[7:0]};
            end
            OP_JMP: begin
                word_ok = 1'b1;
                word_d  = {op, imm};
            end
            default: begin
                word_ok = 1'b0;
                word_d  = '0;
            end
        endcase
    end

    assign transfer      = bus.i_valid && (state_q == S_LOAD);
    assign accept        = transfer && word_ok;
    assign reject        = transfer && !word_ok;
    // This accept fills the last free word of the memory
    assign full_hit      = accept && (acc_cnt_q == '1);
    assign start_session = bus.i_start && (state_q != S_LOAD);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.i_start) state_d = S_LOAD;
            S_LOAD: if (transfer && (bus.i_last || full_hit)) state_d = S_DONE;
            S_DONE: if (bus.i_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-derived outputs
    always_comb begin
        bus.o_ready = (state_q == S_LOAD);
        bus.o_done  = (state_q == S_DONE);
        bus.o_busy  = (state_q == S_LOAD) || we_q;
    end

    // Write pipeline, pointer, counters and sticky error
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q     <= '0;
            acc_cnt_q <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q    <= accept;
            // o_count follows the write that is ending at this edge
            count_q <= count_q + {{IMEM_ADDR_WIDTH{1'b0}}, we_q};
            if (accept) begin
                waddr_q   <= ptr_q;
                wdata_q   <= word_d;
                ptr_q     <= ptr_q + IMEM_ADDR_WIDTH'(1);
                acc_cnt_q <= acc_cnt_q + IMEM_ADDR_WIDTH'(1);
            end
            if (reject) begin
                error_q <= 1'b1;
            end
            // A new session overrides any bookkeeping from the old one
            if (start_session) begin
                ptr_q     <= bus.i_base_addr;
                acc_cnt_q <= '0;
                count_q   <= '0;
                error_q   <= 1'b0;
            end
        end
    end

    assign bus.o_imem_we    = we_q;
    assign bus.o_imem_addr  = waddr_q;
    assign bus.o_imem_wdata = wdata_q;
    assign bus.o_error      = error_q;
    assign bus.o_count      = count_q;

endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed table, hand sequences for
// session corners, and a randomized session against a reference model.
module tb_inst_encode;
    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LDR  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [7:0] FUNCT_SUB = 8'h02;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs1;
        logic [1:0]  rs2;
        logic [7:0]  funct;
        logic [13:0] imm;
        logic        last;
        logic        ok;
        logic [17:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_encode_if bus ();

    inst_encode dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_ptr;
    int         exp_acc;
    logic       exp_err;
    vec_t       tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no transfer at its opening edge: nothing may be written
    task automatic idle();
        step();
        check("idle_no_write", {31'd0, bus.o_imem_we}, 32'd0);
    endtask

    // Reference model: legality and word value from the encoding rules
    function automatic bit ref_itype(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR) || (op == OP_ADDI) ||
               (op == OP_SUBI) || (op == OP_BNE);
    endfunction

    function automatic bit ref_ok(input logic [3:0] op, input logic [13:0] imm);
        int s;
        if (int'(op) > 6) return 1'b0;
        if (ref_itype(op)) begin
            s = int'(imm);
            if (s >= 8192) s = s - 16384;
            return (s >= -128) && (s <= 127);
        end
        return 1'b1;
    endfunction

    function automatic logic [17:0] ref_word(input vec_t v);
        int w;
        w = int'(v.op) * 16384;
        if (v.op == OP_R)
            w = w + int'(v.rd) * 4096 + int'(v.rs1) * 1024 + int'(v.rs2) * 256 + int'(v.funct);
        else if (v.op == OP_JMP)
            w = w + int'(v.imm);
        else
            w = w + int'(v.rd) * 4096 + int'(v.rs1) * 1024 + (int'(v.imm) % 256);
        return w[17:0];
    endfunction

    task automatic start_session(input logic [7:0] base);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        step();
        bus.i_start = 1'b0;
        check("start_ready", {31'd0, bus.o_ready}, 32'd1);
        check("start_done",  {31'd0, bus.o_done},  32'd0);
        check("start_error", {31'd0, bus.o_error}, 32'd0);
        check("start_count", {23'd0, bus.o_count}, 32'd0);
        exp_ptr = base;
        exp_acc = 0;
        exp_err = 1'b0;
    endtask

    task automatic send(input vec_t v);
        bit exp_done;
        check("ready_before_xfer", {31'd0, bus.o_ready}, 32'd1);
        bus.i_opcode = v.op;
        bus.i_rd     = v.rd;
        bus.i_rs1    = v.rs1;
        bus.i_rs2    = v.rs2;
        bus.i_funct  = v.funct;
        bus.i_imm    = v.imm;
        bus.i_last   = v.last;
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        if (v.ok) begin
            check("write_we",    {31'd0, bus.o_imem_we},    32'd1);
            check("write_addr",  {24'd0, bus.o_imem_addr},  {24'd0, exp_ptr});
            check("write_wdata", {14'd0, bus.o_imem_wdata}, {14'd0, v.word});
            exp_ptr++;
            exp_acc++;
        end else begin
            check("reject_no_write", {31'd0, bus.o_imem_we}, 32'd0);
            exp_err = 1'b1;
        end
        exp_done = v.last || (v.ok && exp_acc == 256);
        check("xfer_done",  {31'd0, bus.o_done},  {31'd0, exp_done});
        check("xfer_ready", {31'd0, bus.o_ready}, {31'd0, !exp_done});
        check("xfer_error", {31'd0, bus.o_error}, {31'd0, exp_err});
        check("xfer_busy",  {31'd0, bus.o_busy},  {31'd0, (!exp_done) || v.ok});
    endtask

    task automatic finish_session();
        idle();
        check("end_count", {23'd0, bus.o_count}, exp_acc);
        check("end_busy",  {31'd0, bus.o_busy},  32'd0);
        check("end_done",  {31'd0, bus.o_done},  32'd1);
        check("end_ready", {31'd0, bus.o_ready}, 32'd0);
        check("end_error", {31'd0, bus.o_error}, {31'd0, exp_err});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    {31'd0, bus.o_imem_we},    32'd0);
        check({tag, "_ready"}, {31'd0, bus.o_ready},      32'd0);
        check({tag, "_busy"},  {31'd0, bus.o_busy},       32'd0);
        check({tag, "_done"},  {31'd0, bus.o_done},       32'd0);
        check({tag, "_error"}, {31'd0, bus.o_error},      32'd0);
        check({tag, "_count"}, {23'd0, bus.o_count},      32'd0);
        check({tag, "_addr"},  {24'd0, bus.o_imem_addr},  32'd0);
        check({tag, "_wdata"}, {14'd0, bus.o_imem_wdata}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   sv;

        tbl[0] = '{OP_ADDI, 2'd1, 2'd2, 2'd0, 8'h00, 14'h0005, 1'b0, 1'b1, {OP_ADDI, 2'd1, 2'd2, 2'b00, 8'h05}};
        tbl[1] = '{OP_R,    2'd3, 2'd1, 2'd2, FUNCT_SUB, 14'h0000, 1'b0, 1'b1, {OP_R, 2'd3, 2'd1, 2'd2, FUNCT_SUB}};
        tbl[2] = '{OP_JMP,  2'd0, 2'd0, 2'd0, 8'h00, 14'h0004, 1'b1, 1'b1, {OP_JMP, 14'h0004}};
        tbl[3] = '{4'hF,    2'd1, 2'd1, 2'd1, 8'h11, 14'h0001, 1'b0, 1'b0, 18'h0};
        tbl[4] = '{OP_SUBI, 2'd1, 2'd0, 2'd0, 8'h00, 14'h0100, 1'b0, 1'b0, 18'h0};
        tbl[5] = '{OP_BNE,  2'd2, 2'd2, 2'd0, 8'h00, 14'h0080, 1'b0, 1'b0, 18'h0};
        tbl[6] = '{OP_LDR,  2'd2, 2'd3, 2'd0, 8'h00, 14'h3F80, 1'b1, 1'b1, {OP_LDR, 2'd2, 2'd3, 2'b00, 8'h80}};
        tbl[7] = '{OP_BNE,  2'd0, 2'd1, 2'd0, 8'h00, 14'h007F, 1'b1, 1'b1, {OP_BNE, 2'd0, 2'd1, 2'b00, 8'h7F}};

        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_valid     = 1'b0;
        bus.i_last      = 1'b0;
        bus.i_opcode    = '0;
        bus.i_rd        = '0;
        bus.i_rs1       = '0;
        bus.i_rs2       = '0;
        bus.i_funct     = '0;
        bus.i_imm       = '0;
        exp_ptr         = '0;
        exp_acc         = 0;
        exp_err         = 1'b0;
        #12;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Valid held in IDLE: no transfer
        bus.i_opcode = OP_JMP;
        bus.i_valid  = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        check("idle_stall_count", {23'd0, bus.o_count}, 32'd0);
        check("idle_stall_ready", {31'd0, bus.o_ready}, 32'd0);
        bus.i_valid = 1'b0;

        // Three back-to-back transfers from base 0x10
        start_session(8'h10);
        for (int i = 0; i < 3; i++) send(tbl[i]);
        finish_session();

        // Valid held in DONE: no transfer, count unchanged
        bus.i_valid = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        check("done_stall_count", {23'd0, bus.o_count}, 32'd3);
        check("done_stall_done",  {31'd0, bus.o_done},  32'd1);
        bus.i_valid = 1'b0;

        // Rejections with valid toggling, restarted from DONE
        start_session(8'h20);
        for (int i = 3; i < 7; i++) begin
            send(tbl[i]);
            if (i < 6) idle();
        end
        finish_session();

        // Restart clears sticky error and done
        start_session(8'h40);
        send(tbl[7]);
        finish_session();

        // i_last on a rejected transfer still ends the session
        start_session(8'h50);
        v = tbl[3];
        v.last = 1'b1;
        send(v);
        finish_session();

        // Randomized session against the reference model
        start_session(8'($urandom));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) v.op = 4'($urandom_range(0, 15));
            else                           v.op = 4'($urandom_range(0, 6));
            v.rd    = 2'($urandom);
            v.rs1   = 2'($urandom);
            v.rs2   = 2'($urandom);
            v.funct = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                sv    = int'($urandom_range(0, 255)) - 128;
                v.imm = sv[13:0];
            end else begin
                v.imm = 14'($urandom);
            end
            v.last = (i == 39);
            v.ok   = ref_ok(v.op, v.imm);
            v.word = ref_word(v);
            send(v);
            if (i < 39 && $urandom_range(0, 2) == 0) idle();
        end
        finish_session();

        // Full memory from base 0xFE: wraps, ends after 256 words
        start_session(8'hFE);
        for (int i = 0; i < 256; i++) begin
            v.op    = OP_STR;
            v.rd    = 2'($urandom);
            v.rs1   = 2'($urandom);
            v.rs2   = 2'd0;
            v.funct = 8'd0;
            sv      = int'($urandom_range(0, 255)) - 128;
            v.imm   = sv[13:0];
            v.last  = 1'b0;
            v.ok    = ref_ok(v.op, v.imm);
            v.word  = ref_word(v);
            send(v);
        end
        finish_session();
        check("full_count", {23'd0, bus.o_count}, 32'd256);

        // Asynchronous reset while a write is pending
        start_session(8'h80);
        send(tbl[0]);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        #2;
        rst = 1'b0;
        idle();
        check("post_reset_ready", {31'd0, bus.o_ready}, 32'd0);
        check("post_reset_count", {23'd0, bus.o_count}, 32'd0);
        check("post_reset_done",  {31'd0, bus.o_done},  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_encode.md
# inst_encode

Instruction encoder and program loader: the write-side counterpart of `inst_decode`. It accepts instruction fields over a valid/ready stream and packs them into 18-bit instruction words in the layout that `inst_decode` and the datapath expect. It writes each word into instruction memory at consecutive addresses starting from a programmed base address. It is used for boot-time program loading and by testbenches that generate programs.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 2: register specifier width.
- `OPCODE_WIDTH`, 4: opcode width.
- `FUNCTION_WIDTH`, 8: R-type funct width.
- `INST_WIDTH`, 18: instruction word width.
- `IMEM_ADDR_WIDTH`, 8: instruction memory address width; depth is 2^IMEM_ADDR_WIDTH.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  begin a load session; sampled in IDLE and DONE.
- `i_base_addr`  in  IMEM_ADDR_WIDTH  first write address, captured on `i_start`.
- `i_valid`  in  1  field set presented.
- `o_ready`  out  1  encoder can accept a field set.
- `i_last`  in  1  current field set is the final instruction of the session.
- `i_opcode`  in  OPCODE_WIDTH  opcode, using the `opcode_defs.vh` macros.
- `i_rd`, `i_rs1`, `i_rs2`  in  ADDRESS_WIDTH each  register fields.
- `i_funct`  in  FUNCTION_WIDTH  R-type funct.
- `i_imm`  in  14  immediate; 8 LSBs are used for I-type, all 14 bits for J-type.
- `o_imem_we`  out  1  instruction memory write enable.
- `o_imem_addr`  out  IMEM_ADDR_WIDTH  write address.
- `o_imem_wdata`  out  INST_WIDTH  encoded word.
- `o_busy`  out  1  state is LOAD or a write is pending.
- `o_done`  out  1  session complete; held until the next `i_start` or reset.
- `o_error`  out  1  sticky; at least one field set was rejected this session.
- `o_count`  out  IMEM_ADDR_WIDTH+1  number of words written this session.

## Operation
- States: IDLE, LOAD, DONE. Reset state is IDLE.
- Every output resets to 0.
- IDLE: `o_ready`=0. On `i_start`=1:
  - go to LOAD;
  - write pointer <= `i_base_addr`;
  - `o_count`, `o_error`, `o_done` <= 0.
- LOAD: `o_ready`=1. A transfer occurs in any cycle with `i_valid`=1 and `o_ready`=1. `i_start` is ignored.
- Word formats, selected by opcode:
  - R_TYPE: {opcode, rd, rs1, rs2, funct}.
  - LDR, STR, ADDI, SUBI, BNE: {opcode, rd, rs1, 2'b00, imm[7:0]}.
  - JMP: {opcode, imm[13:0]}.
- Rejected transfers:
  - Cases: an undefined opcode, or an I-type whose `i_imm[13:8]` is not a sign extension of `i_imm[7]`.
  - A rejected transfer writes nothing and does not advance the pointer or `o_count`.
  - It sets `o_error`, which stays set until the next `i_start` or reset.
  - `i_last` on a rejected transfer is still honoured.
- Accepted transfers:
  - The encoded word and address are registered.
  - The pointer increments modulo 2^IMEM_ADDR_WIDTH.
  - `o_count` increments when the write issues.
- LOAD goes to DONE after a transfer that either carries `i_last`=1 or is the 2^IMEM_ADDR_WIDTH-th accepted word (memory full). A full memory does not set `o_error`.
- DONE: `o_ready`=0, `o_done`=1. `i_start` starts a new session exactly as from IDLE.

## Timing
- Write latency is 1 cycle: a transfer at edge N drives `o_imem_we`=1 with its address and word during cycle N+1, for exactly one cycle.
- Back-to-back transfers give back-to-back writes to consecutive addresses, at 1 word per cycle.
- After the final transfer at edge N:
  - `o_ready` falls in cycle N+1;
  - `o_done` rises in cycle N+1, together with the last write;
  - `o_busy` falls in cycle N+2.
- `o_count` is updated at the edge that ends the write cycle.
- The pointer wraps from 2^W-1 to 0, so a nonzero base fills the top of memory and then the bottom.
- Asserting `i_rst` mid-session immediately forces `o_imem_we`=0 and drops any pending write. All state clears and the encoder returns to IDLE.

## Test plan
- Base 8'h10, three back-to-back transfers, then an idle cycle:
  - Transfers: ADDI rd=1 rs1=2 imm=5; R_TYPE FUNCT_SUB rd=3 rs1=1 rs2=2; JMP imm=14'h0004 with `i_last`.
  - Required: writes at 10/11/12 of {`ADDI`,2'd1,2'd2,2'b00,8'h05}, {`R_TYPE`,2'd3,2'd1,2'd2,`FUNCT_SUB`}, {`JMP`,14'h0004}.
  - Required: `o_count`=3, `o_done`=1, `o_error`=0.
- Rejection, with `i_valid` toggling:
  - Send an undefined opcode, then SUBI with imm=14'h0100, then a valid LDR with `i_last`.
  - Required: a single write at the base address, `o_error`=1, `o_count`=1.
- Full memory: base 8'hFE, IMEM_ADDR_WIDTH=8, 256 valid STRs without `i_last`.
  - Required: addresses FE, FF, 00, …, FD.
  - Required: DONE after the 256th transfer, `o_count`=256, `o_error`=0, `o_ready`=0.
- Reset mid-session: assert `i_rst` asynchronously in the cycle after a transfer.
  - Required: `o_imem_we` drops immediately, no write completes, and all outputs are 0 after reset.
- Restart from DONE: pulse `i_start` with base 8'h40, then send one word with `i_last`.
  - Required: `o_done` and `o_error` clear, then the write lands at 8'h40 with `o_count`=1.
- Handshake stall: hold `i_valid`=1 in IDLE and DONE.
  - Required: no writes, and `o_count` unchanged.
